// File: rtl/vpe_sweep_ctrl.sv
// vpe_sweep_ctrl: sequencer for one row of VPE processing elements.
//
// Programs the clause SRAM one word at a time from a valid/ready stream, then
// precharges the array and runs repeated update sweeps (one VUL_EN pulse per
// variable followed by SETTLE idle cycles).  After every sweep the systolic
// SATISFY is sampled; the run stops when satisfied, at the sweep limit, or on
// abort.
//
// Optional feature macro: VPE_EARLY_EXIT_EN
//   When defined, SATISFY is also sampled on the last settle cycle of every
//   variable and a hit ends the run immediately without counting the
//   partial sweep.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_start, i_prog_skip      start a run (IDLE only), optionally skip programming
//   i_abort                   return to IDLE from any state
//   i_max_sweep, i_merge_cfg  run configuration latched at start
//   i_prog_*, o_prog_ready    program word stream (valid/ready)
//   o_wl_sw, o_wl_sign,
//   o_bl_en, o_sram_state     SRAM write drive
//   o_v_pre, o_var_state,
//   o_vul_en, o_merge         array update drive
//   i_satisfy                 AND-reduced satisfy from the array
//   o_busy, o_done,
//   o_sat_found, o_prog_err,
//   o_sweep_cnt               status
module vpe_sweep_ctrl #(
    parameter int unsigned NVAR    = 60,
    parameter int unsigned NGRP    = 8,
    parameter int unsigned WR_CYC  = 2,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned SWEEP_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_prog_skip,
    input  logic               i_abort,
    input  logic [SWEEP_W-1:0] i_max_sweep,
    input  logic               i_merge_cfg,
    input  logic               i_prog_valid,
    output logic               o_prog_ready,
    input  logic [5:0]         i_prog_row,
    input  logic [2:0]         i_prog_grp,
    input  logic               i_prog_sign,
    input  logic               i_prog_last,
    output logic [NVAR-1:0]    o_wl_sw,
    output logic               o_wl_sign,
    output logic [NGRP-1:0]    o_bl_en,
    output logic               o_sram_state,
    output logic               o_v_pre,
    output logic               o_var_state,
    output logic [NVAR-1:0]    o_vul_en,
    output logic               o_merge,
    input  logic               i_satisfy,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_sat_found,
    output logic               o_prog_err,
    output logic [SWEEP_W-1:0] o_sweep_cnt
);

    localparam int unsigned IDX_W = (NVAR > 1) ? $clog2(NVAR) : 1;
    localparam int unsigned WC_W  = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
    localparam int unsigned SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StProg,
        StWrite,
        StPre,
        StUpd,
        StSettle,
        StCheck,
        StFin
    } state_e;

    state_e             r_state,     w_state_nxt;
    logic [WC_W-1:0]    r_wcnt,      w_wcnt_nxt;
    logic [SC_W-1:0]    r_scnt,      w_scnt_nxt;
    logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
    logic [5:0]         r_row,       w_row_nxt;
    logic [2:0]         r_grp,       w_grp_nxt;
    logic               r_sign,      w_sign_nxt;
    logic               r_last,      w_last_nxt;
    logic [SWEEP_W-1:0] r_max,       w_max_nxt;
    logic               r_merge,     w_merge_nxt;
    logic [SWEEP_W-1:0] r_sweep_cnt, w_sweep_cnt_nxt;
    logic               r_sat_found, w_sat_found_nxt;
    logic               r_prog_err,  w_prog_err_nxt;

    logic               w_prog_legal;
    logic               w_var_done;
    logic [SWEEP_W-1:0] w_cnt_inc;

    assign w_prog_legal = (32'(i_prog_row) < NVAR) && (32'(i_prog_grp) < NGRP);
    // Sweep counter saturates instead of wrapping.
    assign w_cnt_inc = (&r_sweep_cnt) ? r_sweep_cnt : r_sweep_cnt + SWEEP_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_scnt_nxt      = r_scnt;
        w_idx_nxt       = r_idx;
        w_row_nxt       = r_row;
        w_grp_nxt       = r_grp;
        w_sign_nxt      = r_sign;
        w_last_nxt      = r_last;
        w_max_nxt       = r_max;
        w_merge_nxt     = r_merge;
        w_sweep_cnt_nxt = r_sweep_cnt;
        w_sat_found_nxt = r_sat_found;
        w_prog_err_nxt  = r_prog_err;
        w_var_done      = 1'b0;

        if (i_abort) begin
            w_state_nxt     = StIdle;
            w_sat_found_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_max_nxt       = i_max_sweep;
                        w_merge_nxt     = i_merge_cfg;
                        w_sweep_cnt_nxt = '0;
                        w_sat_found_nxt = 1'b0;
                        w_prog_err_nxt  = 1'b0;
                        w_state_nxt     = i_prog_skip ? StPre : StProg;
                    end
                end
                StProg: begin
                    if (i_prog_valid) begin
                        if (w_prog_legal) begin
                            w_row_nxt   = i_prog_row;
                            w_grp_nxt   = i_prog_grp;
                            w_sign_nxt  = i_prog_sign;
                            w_last_nxt  = i_prog_last;
                            w_wcnt_nxt  = '0;
                            w_state_nxt = StWrite;
                        end else begin
                            // Out-of-range word is dropped, but LAST still ends programming.
                            w_prog_err_nxt = 1'b1;
                            if (i_prog_last) begin
                                w_state_nxt = StPre;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (r_wcnt == WC_W'(WR_CYC - 1)) begin
                        w_state_nxt = r_last ? StPre : StProg;
                    end else begin
                        w_wcnt_nxt = r_wcnt + WC_W'(1);
                    end
                end
                StPre: begin
                    w_idx_nxt   = '0;
                    w_state_nxt = StUpd;
                end
                StUpd: begin
                    if (SETTLE == 0) begin
                        w_var_done = 1'b1;
                    end else begin
                        w_scnt_nxt  = '0;
                        w_state_nxt = StSettle;
                    end
                end
                StSettle: begin
                    if (r_scnt == SC_W'(SETTLE - 1)) begin
                        w_var_done = 1'b1;
                    end else begin
                        w_scnt_nxt = r_scnt + SC_W'(1);
                    end
                end
                StCheck: begin
                    w_sweep_cnt_nxt = w_cnt_inc;
                    if (i_satisfy) begin
                        w_sat_found_nxt = 1'b1;
                        w_state_nxt     = StFin;
                    end else if ((r_max != '0) && (w_cnt_inc == r_max)) begin
                        w_state_nxt = StFin;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = StUpd;
                    end
                end
                StFin: begin
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase

            // End of one variable's pulse + settle window.
            if (w_var_done) begin
`ifdef VPE_EARLY_EXIT_EN
                if (i_satisfy) begin
                    w_sat_found_nxt = 1'b1;
                    w_state_nxt     = StFin;
                end else
`endif
                if (r_idx == IDX_W'(NVAR - 1)) begin
                    w_state_nxt = StCheck;
                end else begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = StUpd;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_wcnt      <= '0;
            r_scnt      <= '0;
            r_idx       <= '0;
            r_row       <= '0;
            r_grp       <= '0;
            r_sign      <= 1'b0;
            r_last      <= 1'b0;
            r_max       <= '0;
            r_merge     <= 1'b0;
            r_sweep_cnt <= '0;
            r_sat_found <= 1'b0;
            r_prog_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_scnt      <= w_scnt_nxt;
            r_idx       <= w_idx_nxt;
            r_row       <= w_row_nxt;
            r_grp       <= w_grp_nxt;
            r_sign      <= w_sign_nxt;
            r_last      <= w_last_nxt;
            r_max       <= w_max_nxt;
            r_merge     <= w_merge_nxt;
            r_sweep_cnt <= w_sweep_cnt_nxt;
            r_sat_found <= w_sat_found_nxt;
            r_prog_err  <= w_prog_err_nxt;
        end
    end

    // All drive outputs decode from state and registered copies only.
    always_comb begin
        o_prog_ready = (r_state == StProg);
        o_sram_state = (r_state == StWrite);
        o_wl_sw      = (r_state == StWrite) ? (NVAR'(1) << r_row) : '0;
        o_bl_en      = (r_state == StWrite) ? (NGRP'(1) << r_grp) : '0;
        o_wl_sign    = (r_state == StWrite) && r_sign;
        o_v_pre      = (r_state == StPre);
        o_var_state  = (r_state == StUpd) || (r_state == StSettle) || (r_state == StCheck);
        o_vul_en     = (r_state == StUpd) ? (NVAR'(1) << r_idx) : '0;
        o_merge      = r_merge;
        o_busy       = (r_state != StIdle);
        o_done       = (r_state == StFin);
        o_sat_found  = r_sat_found;
        o_prog_err   = r_prog_err;
        o_sweep_cnt  = r_sweep_cnt;
    end

endmodule

// File: tb/tb_vpe_sweep_ctrl.sv
module tb_vpe_sweep_ctrl;

    localparam int NVAR    = 60;
    localparam int NGRP    = 8;
    localparam int WR_CYC  = 2;
    localparam int SETTLE  = 2;
    localparam int SWEEP_W = 16;
    localparam int SLOT    = 1 + SETTLE;      // cycles per variable
    localparam int P       = NVAR * SLOT + 1; // cycles per sweep incl. CHECK
    localparam int NEVER   = 1 << 30;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0, prog_skip = 1'b0, abort_in = 1'b0;
    logic [SWEEP_W-1:0] max_sweep = '0;
    logic               merge_cfg = 1'b0;
    logic               prog_valid = 1'b0, prog_sign = 1'b0, prog_last = 1'b0;
    logic [5:0]         prog_row = '0;
    logic [2:0]         prog_grp = '0;
    logic               satisfy = 1'b0;
    logic               prog_ready, wl_sign, sram_state, v_pre, var_state, merge;
    logic               busy, done, sat_found, prog_err;
    logic [NVAR-1:0]    wl_sw, vul_en;
    logic [NGRP-1:0]    bl_en;
    logic [SWEEP_W-1:0] sweep_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vpe_sweep_ctrl #(
        .NVAR(NVAR), .NGRP(NGRP), .WR_CYC(WR_CYC), .SETTLE(SETTLE), .SWEEP_W(SWEEP_W)
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_prog_skip(prog_skip),
        .i_abort(abort_in), .i_max_sweep(max_sweep), .i_merge_cfg(merge_cfg),
        .i_prog_valid(prog_valid), .o_prog_ready(prog_ready), .i_prog_row(prog_row),
        .i_prog_grp(prog_grp), .i_prog_sign(prog_sign), .i_prog_last(prog_last),
        .o_wl_sw(wl_sw), .o_wl_sign(wl_sign), .o_bl_en(bl_en), .o_sram_state(sram_state),
        .o_v_pre(v_pre), .o_var_state(var_state), .o_vul_en(vul_en), .o_merge(merge),
        .i_satisfy(satisfy), .o_busy(busy), .o_done(done), .o_sat_found(sat_found),
        .o_prog_err(prog_err), .o_sweep_cnt(sweep_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wl"}, 64'(wl_sw), 64'd0);
        chk({tag, "_vul"}, 64'(vul_en), 64'd0);
        chk({tag, "_misc"}, 64'({prog_ready, wl_sign, bl_en, sram_state, v_pre, var_state,
                                 merge, busy, done, sat_found, prog_err, sweep_cnt}), 64'd0);
    endtask

    // Reference: cycle k=0 is PRE; SATISFY is high on every cycle k >= rise.
    // Each sweep is NVAR slots of (1 pulse + SETTLE idle) followed by one CHECK cycle.
    function automatic void model_run(input int m, input int rise, output int k_done,
                                      output int cnt, output bit sat);
        k_done = NEVER;
        cnt    = 0;
        sat    = 1'b0;
        for (int k = 1; k < 100000; k++) begin
            int o = (k - 1) % P;
            int s = (k - 1) / P;
            bit satk = (k >= rise);
`ifdef VPE_EARLY_EXIT_EN
            if (o < P - 1 && (o % SLOT) == SLOT - 1 && satk) begin
                k_done = k + 1; cnt = s; sat = 1'b1;
                return;
            end
`endif
            if (o == P - 1) begin
                if (satk) begin
                    k_done = k + 1; cnt = s + 1; sat = 1'b1;
                    return;
                end
                if (m != 0 && s + 1 == m) begin
                    k_done = k + 1; cnt = s + 1; sat = 1'b0;
                    return;
                end
            end
        end
    endfunction

    function automatic logic [63:0] model_vul(input int k);
        int o = (k - 1) % P;
        logic [63:0] one = 64'd1;
        if (o < P - 1 && (o % SLOT) == 0) return one << (o / SLOT);
        return 64'd0;
    endfunction

    // Entered at the PRE cycle. abort_at > 0 raises ABORT on that cycle.
    task automatic run_from_pre(input int m, input int rise, input bit mg, input int abort_at,
                                input string tag);
        int  k_done, cnt;
        bit  sat;
        model_run(m, rise, k_done, cnt, sat);
        chk({tag, "_pre"}, 64'({v_pre, var_state, busy}), 64'(3'b101));
        chk({tag, "_merge"}, 64'(merge), 64'(mg));
        for (int k = 1; k < k_done && k < 20000; k++) begin
            tick();
            satisfy = (k >= rise);
            chk({tag, "_vul"}, 64'(vul_en), model_vul(k));
            chk({tag, "_vs_done"}, 64'({var_state, done, v_pre}), 64'(3'b100));
            if (k == abort_at) begin
                abort_in = 1'b1;
                tick();
                abort_in = 1'b0;
                satisfy  = 1'b0;
                chk({tag, "_ab_vul"}, 64'(vul_en), 64'd0);
                chk({tag, "_ab_st"}, 64'({busy, var_state, done, sat_found}), 64'd0);
                chk({tag, "_ab_cnt"}, 64'(sweep_cnt), 64'((k - 1) / P));
                return;
            end
        end
        tick();
        satisfy = 1'b0;
        chk({tag, "_done"}, 64'({done, var_state}), 64'(2'b10));
        chk({tag, "_sat"}, 64'(sat_found), 64'(sat));
        chk({tag, "_cnt"}, 64'(sweep_cnt), 64'(cnt));
        tick();
        chk({tag, "_idle"}, 64'({busy, done, sat_found}), 64'({2'b00, sat}));
        chk({tag, "_cnt_hold"}, 64'(sweep_cnt), 64'(cnt));
    endtask

    task automatic start_run(input bit skip, input int m, input bit mg);
        prog_skip = skip;
        max_sweep = SWEEP_W'(m);
        merge_cfg = mg;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic put_word(input int row, input int grp, input bit sgn, input bit lst);
        prog_row   = 6'(row);
        prog_grp   = 3'(grp);
        prog_sign  = sgn;
        prog_last  = lst;
        prog_valid = 1'b1;
        tick();
        prog_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] one = 64'd1;

        // Reset state
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Programming: legal word, illegal word, legal LAST word, then a one-sweep run
        start_run(1'b0, 1, 1'b0);
        chk("prog_ready", 64'({prog_ready, busy, prog_err}), 64'(3'b110));
        put_word(5, 2, 1'b1, 1'b0);
        chk("w1_c1", 64'({sram_state, prog_ready, wl_sign, bl_en}), 64'({3'b101, 8'h04}));
        chk("w1_c1_wl", 64'(wl_sw), one << 5);
        tick();
        chk("w1_c2", 64'({sram_state, bl_en}), 64'({1'b1, 8'h04}));
        chk("w1_c2_wl", 64'(wl_sw), one << 5);
        tick();
        chk("w1_end", 64'({sram_state, prog_ready}), 64'(2'b01));
        chk("w1_end_wl", 64'(wl_sw), 64'd0);
        put_word(60, 0, 1'b1, 1'b0);
        chk("bad_err", 64'({prog_err, sram_state, prog_ready}), 64'(3'b101));
        chk("bad_wl", 64'(wl_sw), 64'd0);
        put_word(59, 7, 1'b0, 1'b1);
        chk("w2_c1", 64'({sram_state, wl_sign, bl_en}), 64'({2'b10, 8'h80}));
        chk("w2_c1_wl", 64'(wl_sw), one << 59);
        tick();
        chk("w2_c2", 64'({sram_state, bl_en}), 64'({1'b1, 8'h80}));
        tick();
        run_from_pre(1, NEVER, 1'b0, 0, "prog");
        chk("err_sticky", 64'(prog_err), 64'd1);

        // Sweep limit 3, never satisfied
        start_run(1'b1, 3, 1'b1);
        chk("err_clear", 64'(prog_err), 64'd0);
        run_from_pre(3, NEVER, 1'b1, 0, "limit");

        // Satisfied during sweep 2, unlimited mode
        start_run(1'b1, 0, 1'b0);
        run_from_pre(0, P + 5, 1'b0, 0, "sat2");

        // Randomized runs against the reference model
        for (int i = 0; i < 4; i++) begin
            int m  = $urandom_range(0, 3);
            int r  = $urandom_range(1, 3 * P);
            bit mg = 1'($urandom_range(0, 1));
            start_run(1'b1, m, mg);
            run_from_pre(m, r, mg, 0, $sformatf("rnd%0d", i));
        end

        // Abort while VUL_EN=4 in sweep 2, then START+ABORT, then a clean START
        start_run(1'b1, 0, 1'b0);
        run_from_pre(0, NEVER, 1'b0, P + 7, "abort");
        start    = 1'b1;
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("start_abort", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        chk("restart", 64'({busy, v_pre}), 64'(2'b11));
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;

        // Reset mid-write
        start_run(1'b0, 2, 1'b1);
        put_word(3, 1, 1'b1, 1'b0);
        chk("pre_rst_sram", 64'(sram_state), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vpe_sweep_ctrl.md
Name: vpe_sweep_ctrl

Overview:
- Sequencer for one row of VPE_MASTER/slave processing elements.
- First programs the clause SRAM. Word lines and BL_EN groups are driven one word at a time from a valid/ready program stream.
- Then runs a precharge plus repeated update sweeps: pulses each variable's VUL_EN in turn and lets it settle.
- After each sweep, samples the array's systolic SATISFY. Stops when satisfied, at a sweep limit, or on abort.

Parameters:
- NVAR, 60, number of variables (VPEs) and width of WL_SW / VUL_EN
- NGRP, 8, number of bit-line enable groups (BL_EN width)
- WR_CYC, 2, cycles SRAM_STATE/WL_SW are held per program word (>=1)
- SETTLE, 2, idle cycles after each VUL_EN pulse (>=0)
- SWEEP_W, 16, sweep counter width

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  begin a run; sampled in IDLE only
- PROG_SKIP  in  1  sampled with START; 1 = skip programming, go to PRE
- ABORT  in  1  return to IDLE next cycle from any state
- MAX_SWEEP  in  SWEEP_W  sweep limit, sampled at START; 0 = unlimited
- MERGE_CFG  in  1  sampled at START, driven on MERGE for the whole run
- PROG_VALID  in  1  program word valid
- PROG_READY  out  1  program word accepted when VALID&READY
- PROG_ROW  in  6  target variable row (word line index)
- PROG_GRP  in  3  target BL_EN group
- PROG_SIGN  in  1  literal sign, driven on WL_SIGN
- PROG_LAST  in  1  final program word
- WL_SW  out  NVAR  one-hot word line during write, else 0
- WL_SIGN  out  1  sign of current write
- BL_EN  out  NGRP  one-hot group enable during write, else 0
- SRAM_STATE  out  1  1 while a write is in progress
- V_PRE  out  1  single-cycle precharge pulse
- VAR_STATE  out  1  1 from PRE exit until FIN/IDLE
- VUL_EN  out  NVAR  one-hot update enable pulse
- MERGE  out  1  latched MERGE_CFG
- SATISFY  in  1  AND-reduced satisfy from the array
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse on FIN entry
- SAT_FOUND  out  1  valid from DONE until next START
- PROG_ERR  out  1  sticky: word with PROG_ROW>=NVAR or PROG_GRP>=NGRP was dropped; cleared at START
- SWEEP_CNT  out  SWEEP_W  completed sweeps in current/last run

Behaviour:
- Reset: state IDLE; all outputs 0.
- IDLE: PROG_READY=0. On START, latch MAX_SWEEP and MERGE_CFG; clear SWEEP_CNT, SAT_FOUND and PROG_ERR. Next state is PROG, or PRE if PROG_SKIP=1.
- PROG: PROG_READY=1.
  - Accepted legal word: next cycle enter WRITE.
  - Accepted illegal word: set PROG_ERR; no write. If it carries PROG_LAST, go to PRE; else stay in PROG.
- WRITE: lasts exactly WR_CYC cycles with PROG_READY=0.
  - Drives SRAM_STATE=1, WL_SW=1<<row, BL_EN=1<<grp, WL_SIGN=sign, all from registered copies.
  - Then returns to PROG, or goes to PRE if that word carried LAST.
- PRE: one cycle with V_PRE=1. VAR_STATE is 1 from the next cycle on. Idx=0.
- UPD: one cycle with VUL_EN=1<<idx. Then SETTLE cycles with VUL_EN=0.
  - If idx<NVAR-1: idx++ and repeat UPD.
  - Else go to CHECK.
  - One sweep = NVAR*(1+SETTLE) cycles.
- CHECK: one cycle; samples SATISFY.
  - SATISFY=1: SWEEP_CNT++, SAT_FOUND=1, go to FIN.
  - SATISFY=0: SWEEP_CNT++. If MAX_SWEEP!=0 and the new count==MAX_SWEEP, go to FIN with SAT_FOUND=0. Else idx=0 and go to UPD.
  - SWEEP_CNT saturates at all-ones (it does not wrap). Unlimited mode continues.
- FIN: one cycle with DONE=1; VAR_STATE drops; then IDLE.
- ABORT has priority over every transition:
  - Next cycle is IDLE and every strobe/enable output is 0.
  - A write in progress is truncated.
  - No DONE; SAT_FOUND=0.
  - SWEEP_CNT keeps its value.
- START outside IDLE is ignored.
- START and ABORT together in IDLE: ABORT wins (stays IDLE).
- RESET_N low mid-run: immediate return to reset values.

Optional Feature:
- Macro VPE_EARLY_EXIT_EN.
- Defined: SATISFY is also sampled on the last settle cycle of every variable (on the UPD cycle itself if SETTLE=0). If SATISFY=1, go straight to FIN with SAT_FOUND=1; SWEEP_CNT is not incremented for the partial sweep.
- Undefined: SATISFY is sampled only in CHECK, as described above.

Test Plan:
- Reset/idle: RESET_N low mid-PROG -> all outputs 0; BUSY=0; PROG_READY=0.
- Program (WR_CYC=2): words {row 5, grp 2, sign 1} and {row 59, grp 7, sign 0, LAST} -> WL_SW=bit5 and BL_EN=0x04 with SRAM_STATE=1 for 2 cycles; then WL_SW=bit59 and BL_EN=0x80; then V_PRE pulse.
- Illegal word: row 60 -> PROG_ERR=1, WL_SW stays 0, no SRAM_STATE pulse; a following legal word is still written.
- Sweep limit (NVAR=4, SETTLE=2, MAX_SWEEP=3, SATISFY=0):
  - VUL_EN = 1,2,4,8 every 3 cycles.
  - DONE occurs 3*(12+1)+1 cycles after PRE exit.
  - SAT_FOUND=0, SWEEP_CNT=3.
- Satisfied: SATISFY rises during sweep 2 -> CHECK of sweep 2 gives DONE, SAT_FOUND=1, SWEEP_CNT=2. With VPE_EARLY_EXIT_EN, DONE follows that variable's settle and SWEEP_CNT=1.
- Abort: ABORT during UPD with VUL_EN=4 -> next cycle IDLE, VUL_EN=0, VAR_STATE=0, no DONE; a new START is accepted one cycle later.
